crc_fcs_checker: RTL and testbench
==================================

Name: crc_fcs_checker

Overview:
Receive-side counterpart of the slicing CRC generator. Accepts a byte-lane stream of frames whose last 4 bytes are a CRC-32 FCS (appended LS byte first), checks the FCS with a slicing-by-N table CRC, and strips the FCS from the forwarded stream. It reports pass/fail on the final output beat. It sits between the MAC-side deframer and the packet buffer.

Parameters:
SLICE_LENGTH, 8, bytes per beat; legal values 4, 8 or 16.
INITIAL_CRC, 32'hFFFFFFFF, CRC register value at frame start.
RESIDUE, 32'hDEBB20E3, uninverted CRC register value after a frame plus a correct FCS.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_data  input  8*SLICE_LENGTH  input bytes; lane 0 is first on the wire
in_keep  input  SLICE_LENGTH  byte valid, contiguous from lane 0; must be all-ones on non-last beats
in_valid  input  1  input beat valid
in_last  input  1  final beat of frame (carries the end of the FCS)
in_ready  output  1  input beat accepted when in_valid && in_ready
out_data  output  8*SLICE_LENGTH  forwarded bytes, FCS removed
out_keep  output  SLICE_LENGTH  forwarded byte valid, contiguous from lane 0
out_valid  output  1  output beat valid
out_last  output  1  final forwarded beat of frame
out_ready  input  1  downstream accepts
out_fcs_ok  output  1  valid with out_last; 1 = FCS correct
err_runt  output  1  one-cycle pulse: frame of 4 bytes or fewer dropped

Behaviour:
- Reset: asynchronous on reset_n low. State=IDLE, CRC register=INITIAL_CRC, both beat slots empty, all outputs 0. Reset mid-frame discards the partial frame; nothing further is emitted for it.
- Byte count k: index of the highest set in_keep bit, plus 1.
- CRC: reflected CRC-32, poly 0xEDB88320. Every accepted beat folds its k bytes into the CRC register, lane 0 first. The FCS bytes are included. No output inversion.
- Storage: slot A holds the pending beat; slot B holds a second tail beat.
- IDLE: out_valid=0, in_ready=1.
  - Non-last beat accepted: store in A, go to HOLD.
  - Last beat with k>4: A = first k-4 bytes, go to FLUSH.
  - Last beat with k<=4: drop it, pulse err_runt, reset the CRC to INITIAL_CRC, stay in IDLE.
- HOLD:
  - out_valid = in_valid && !in_last (A presented as a non-last beat).
  - in_ready = in_last ? 1 : out_ready. This is a combinational dependency on in_last and is permitted.
  - Non-last beat handshake: A is emitted and the new beat is written into A in the same cycle.
  - Last beat accepted (nothing emitted that cycle):
    - k>4: A kept full; B = first k-4 bytes.
    - k==4: A becomes the final beat, full.
    - k<4: A becomes the final beat with 4+k bytes (SLICE_LENGTH=8). In general the final beat carries SLICE_LENGTH-(4-k) bytes.
  - Then go to FLUSH.
- FLUSH: in_ready=0.
  - A is presented first, with out_last=0 if B is occupied and out_last=1 otherwise.
  - B, when occupied, is presented next with out_last=1.
  - out_fcs_ok = (CRC register == RESIDUE) on the out_last beat; 0 otherwise.
  - Final-beat handshake: reset the CRC to INITIAL_CRC, clear the slots, go to IDLE.
- Output stability: out_data, out_keep, out_last and out_fcs_ok hold while out_valid && !out_ready.
- Latency and throughput: each beat leaves one input beat later. FLUSH takes 1-2 cycles with no input accepted. A back-to-back frame is accepted the cycle after FLUSH exits.
- Illegal input: non-last beats with in_keep != all-ones are undefined. Simulation assertions flag them.

Optional Feature:
Macro CRC_FCS_CHECKER_STATS_EN.
- Defined: adds outputs stat_good[31:0] and stat_bad[31:0]. They count final-beat handshakes with out_fcs_ok=1 and =0 respectively. They saturate at 32'hFFFFFFFF and are cleared by reset_n only. Runt frames are counted in stat_bad.
- Undefined: the ports and counters do not exist.

Test Plan:
- Good frame, SLICE_LENGTH=8, out_ready=1:
  - Stimulus: beat0 = "12345678" keep 8'hFF; beat1 = '9',26,39,F4,CB keep 8'h1F, last.
  - Response: out beat0 = "12345678" keep FF, last=0; then '9' keep 01, last=1, out_fcs_ok=1.
- Same frame with byte 0x26 flipped to 0x27: identical data/keep; out_fcs_ok=0 on the last beat.
- FCS split across beats:
  - Stimulus: 14-byte frame = 10 data bytes + model FCS; last beat keep 8'h3F (k=6).
  - Response: 2 output beats, keep FF then 03, ok=1.
  - Also 12-byte frame, last keep 0F (k=4): 1 output beat, keep FF, last, ok=1.
  - Also 11-byte frame, k=3: 1 output beat, keep 7F, last, ok=1.
- Runt: a single beat with keep 0F and last -> no output beat, err_runt high for exactly 1 cycle, next frame checks correctly.
- Backpressure and reset:
  - Random out_ready over 50 frames -> no beat lost or duplicated; outputs stable while stalled.
  - reset_n low mid-frame -> out_valid=0 immediately; the following good frame gives ok=1 (stat_good=1 when STATS_EN is defined).

Source files
------------

// File: rtl/crc_fcs_checker.sv
// Receive-side CRC-32 FCS checker: folds each accepted beat into the CRC, strips the 4 FCS bytes
// and flags pass/fail on the final forwarded beat. Define CRC_FCS_CHECKER_STATS_EN for good/bad frame counters.
module crc_fcs_checker #(
    parameter int          SLICE_LENGTH = 8,
    parameter logic [31:0] INITIAL_CRC  = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE      = 32'hDEBB20E3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [8*SLICE_LENGTH-1:0] in_data,
    input  logic [SLICE_LENGTH-1:0]   in_keep,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [8*SLICE_LENGTH-1:0] out_data,
    output logic [SLICE_LENGTH-1:0]   out_keep,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      out_fcs_ok,
`ifdef CRC_FCS_CHECKER_STATS_EN
    output logic [31:0]               stat_good,
    output logic [31:0]               stat_bad,
`endif
    output logic                      err_runt
);
    localparam int          S    = SLICE_LENGTH;
    localparam logic [31:0] POLY = 32'hEDB88320;

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    state_t         state_reg;
    logic [31:0]    crc_reg;
    logic [8*S-1:0] a_data_reg, b_data_reg;
    logic [S-1:0]   a_keep_reg, b_keep_reg;
    logic           a_full_reg, b_full_reg;
    logic           err_runt_reg;

    logic [31:0]    crc_next;
    int             in_k;
    logic           final_hs, runt_hs;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int j = 0; j < 8; j++)
            r = (r[0] ^ d[j]) ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [S-1:0] keep_mask(input int n);
        logic [S-1:0] m;
        for (int i = 0; i < S; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic logic [8*S-1:0] lane_mask(input logic [8*S-1:0] d, input int n);
        logic [8*S-1:0] r;
        for (int i = 0; i < S; i++) r[8*i +: 8] = (i < n) ? d[8*i +: 8] : 8'h00;
        return r;
    endfunction

    // Byte count and the CRC after folding the accepted lanes, lane 0 first.
    always_comb begin
        in_k     = 0;
        crc_next = crc_reg;
        for (int i = 0; i < S; i++) begin
            if (in_keep[i]) begin
                in_k     = i + 1;
                crc_next = crc_byte(crc_next, in_data[8*i +: 8]);
            end
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        out_keep   = '0;
        case (state_reg)
            IDLE:    in_ready = 1'b1;
            HOLD: begin
                in_ready  = in_last ? 1'b1 : out_ready;
                out_valid = in_valid && !in_last;
            end
            FLUSH: begin
                out_valid = a_full_reg || b_full_reg;
                out_last  = a_full_reg ? !b_full_reg : 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
        if (out_valid) begin
            out_data = (state_reg == FLUSH && !a_full_reg) ? b_data_reg : a_data_reg;
            out_keep = (state_reg == FLUSH && !a_full_reg) ? b_keep_reg : a_keep_reg;
        end
    end

    assign out_fcs_ok = out_valid && out_last && (crc_reg == RESIDUE);
    assign err_runt   = err_runt_reg;
    assign final_hs   = (state_reg == FLUSH) && out_valid && out_ready && out_last;
    assign runt_hs    = (state_reg == IDLE) && in_valid && in_last && (in_k <= 4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            crc_reg      <= INITIAL_CRC;
            a_data_reg   <= '0;
            a_keep_reg   <= '0;
            b_data_reg   <= '0;
            b_keep_reg   <= '0;
            a_full_reg   <= 1'b0;
            b_full_reg   <= 1'b0;
            err_runt_reg <= 1'b0;
        end else begin
            err_runt_reg <= 1'b0;
            case (state_reg)
                IDLE: if (in_valid) begin
                    if (!in_last) begin
                        a_data_reg <= in_data;
                        a_keep_reg <= in_keep;
                        a_full_reg <= 1'b1;
                        crc_reg    <= crc_next;
                        state_reg  <= HOLD;
                    end else if (in_k > 4) begin
                        a_data_reg <= lane_mask(in_data, in_k - 4);
                        a_keep_reg <= keep_mask(in_k - 4);
                        a_full_reg <= 1'b1;
                        crc_reg    <= crc_next;
                        state_reg  <= FLUSH;
                    end else begin
                        err_runt_reg <= 1'b1;
                        crc_reg      <= INITIAL_CRC;
                    end
                end
                HOLD: if (in_valid && in_ready) begin
                    crc_reg <= crc_next;
                    if (!in_last) begin
                        a_data_reg <= in_data;
                        a_keep_reg <= in_keep;
                    end else begin
                        // FCS spans both beats when k<4: trim its head off the pending beat.
                        if (in_k > 4) begin
                            b_data_reg <= lane_mask(in_data, in_k - 4);
                            b_keep_reg <= keep_mask(in_k - 4);
                            b_full_reg <= 1'b1;
                        end else if (in_k < 4) begin
                            a_data_reg <= lane_mask(a_data_reg, S - (4 - in_k));
                            a_keep_reg <= keep_mask(S - (4 - in_k));
                        end
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: if (out_valid && out_ready) begin
                    if (a_full_reg && b_full_reg) begin
                        a_full_reg <= 1'b0;
                    end else begin
                        crc_reg    <= INITIAL_CRC;
                        a_full_reg <= 1'b0;
                        b_full_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef CRC_FCS_CHECKER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_good <= '0;
            stat_bad  <= '0;
        end else begin
            if (final_hs && out_fcs_ok && stat_good != 32'hFFFFFFFF)
                stat_good <= stat_good + 32'd1;
            if (((final_hs && !out_fcs_ok) || runt_hs) && stat_bad != 32'hFFFFFFFF)
                stat_bad <= stat_bad + 32'd1;
        end
    end
`else
    logic unused_hs;
    assign unused_hs = final_hs ^ runt_hs;
`endif

    // Only the last beat of a frame may be partially filled.
    a_keep_full: assert property (@(posedge clk) disable iff (!reset_n)
        (in_valid && in_ready && !in_last) |-> (&in_keep));
endmodule

// File: tb/tb_crc_fcs_checker.sv
// Directed bench for crc_fcs_checker: good/bad FCS, FCS split across beats, runts,
// random backpressure and reset mid-frame.
module tb_crc_fcs_checker;
    localparam int S = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [8*S-1:0] in_data = '0;
    logic [S-1:0]  in_keep = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [8*S-1:0] out_data;
    logic [S-1:0]  out_keep;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          out_fcs_ok;
    logic          err_runt;
`ifdef CRC_FCS_CHECKER_STATS_EN
    logic [31:0]   stat_good;
    logic [31:0]   stat_bad;
`endif

    crc_fcs_checker #(.SLICE_LENGTH(S)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .out_fcs_ok(out_fcs_ok),
`ifdef CRC_FCS_CHECKER_STATS_EN
        .stat_good(stat_good), .stat_bad(stat_bad),
`endif
        .err_runt(err_runt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] crc_tab [0:255];
    logic [7:0]  frame_bytes [0:63];
    int          frame_len;

    logic [8*S-1:0] od_q [$];
    logic [S-1:0]   ok_q [$];
    bit             ol_q [$];
    bit             of_q [$];
    int             runt_cycles = 0;
    int             stall_changes = 0;
    bit             rand_ready = 0;

    logic           stalled = 1'b0;
    logic [8*S-1:0] sd;
    logic [S-1:0]   sk;
    logic           sl, sf;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled <= 1'b0;
        end else begin
            if (err_runt) runt_cycles <= runt_cycles + 1;
            if (stalled && (!out_valid || out_data !== sd || out_keep !== sk ||
                            out_last !== sl || out_fcs_ok !== sf))
                stall_changes <= stall_changes + 1;
            stalled <= out_valid && !out_ready;
            sd <= out_data; sk <= out_keep; sl <= out_last; sf <= out_fcs_ok;
            if (out_valid && out_ready) begin
                od_q.push_back(out_data);
                ok_q.push_back(out_keep);
                ol_q.push_back(out_last);
                of_q.push_back(out_fcs_ok);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [31:0] model_crc(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++)
            c = crc_tab[(c[7:0] ^ frame_bytes[i])] ^ (c >> 8);
        return c;
    endfunction

    task automatic make_frame(input int plen, input int seed, input bit corrupt);
        logic [31:0] fcs;
        for (int i = 0; i < plen; i++) frame_bytes[i] = 8'(seed * 7 + i * 13 + 1);
        fcs = ~model_crc(plen);
        for (int i = 0; i < 4; i++) frame_bytes[plen + i] = fcs[8*i +: 8];
        if (corrupt) frame_bytes[plen] = frame_bytes[plen] ^ 8'h01;
        frame_len = plen + 4;
    endtask

    task automatic clear_q();
        od_q.delete(); ok_q.delete(); ol_q.delete(); of_q.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic drive_beat(input logic [8*S-1:0] d, input logic [S-1:0] k, input bit last);
        bit acc;
        int n;
        in_data = d; in_keep = k; in_last = last; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 1000) begin
                n_checks++; n_fail++;
                $display("FAIL drive_timeout: in_ready never seen, required 1");
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame();
        logic [8*S-1:0] d;
        logic [S-1:0]   kp;
        int             k;
        for (int off = 0; off < frame_len; off += S) begin
            k = (frame_len - off < S) ? frame_len - off : S;
            d = '0; kp = '0;
            for (int i = 0; i < k; i++) begin
                d[8*i +: 8] = frame_bytes[off + i];
                kp[i] = 1'b1;
            end
            drive_beat(d, kp, (off + S >= frame_len));
        end
    endtask

    task automatic wait_beats(input int n, input string name);
        int c;
        c = 0;
        while (od_q.size() < n && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (od_q.size() != n) begin
            n_fail++;
            $display("FAIL %s_beats: got %0d beats, required %0d", name, od_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_last, out_fcs_ok, err_runt} !== 4'b0000 || out_keep !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid/last/ok/runt=%b keep=%h, required 0000 keep=00",
                     {out_valid, out_last, out_fcs_ok, err_runt}, out_keep);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic load_check_frame(input logic [7:0] b5);
        logic [7:0] v [0:12];
        v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 13; i++) frame_bytes[i] = v[i];
        frame_bytes[9] = b5;
        frame_len = 13;
    endtask

    task automatic test_good_frame(input logic [7:0] fcs_b0, input bit exp_ok, input string name);
        clear_q();
        load_check_frame(fcs_b0);
        send_frame();
        wait_beats(2, name);
        n_checks++;
        if (od_q[0] !== 64'h3837363534333231 || ok_q[0] !== 8'hFF || ol_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_beat0: data=%h keep=%h last=%b, required 3837363534333231 ff 0",
                     name, od_q[0], ok_q[0], ol_q[0]);
        end
        n_checks++;
        if (od_q[1] !== 64'h39 || ok_q[1] !== 8'h01 || ol_q[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_beat1: data=%h keep=%h last=%b, required 39 01 1",
                     name, od_q[1], ok_q[1], ol_q[1]);
        end
        n_checks++;
        if (of_q[1] !== exp_ok || of_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_fcs_ok: got %b/%b, required 0/%b", name, of_q[0], of_q[1], exp_ok);
        end
    endtask

    task automatic test_fcs_split();
        int          plens [3]    = '{10, 8, 7};
        int          nbeats [3]   = '{2, 1, 1};
        logic [7:0]  lastkeep [3] = '{8'h03, 8'hFF, 8'h7F};
        int          idx;
        for (int t = 0; t < 3; t++) begin
            clear_q();
            make_frame(plens[t], t + 3, 1'b0);
            send_frame();
            wait_beats(nbeats[t], "split");
            idx = nbeats[t] - 1;
            n_checks++;
            if (ok_q[idx] !== lastkeep[t] || ol_q[idx] !== 1'b1 || of_q[idx] !== 1'b1) begin
                n_fail++;
                $display("FAIL split%0d_last: keep=%h last=%b ok=%b, required %h 1 1",
                         t, ok_q[idx], ol_q[idx], of_q[idx], lastkeep[t]);
            end
            for (int b = 0; b < nbeats[t]; b++) begin
                n_checks++;
                for (int i = 0; i < S; i++) begin
                    if (ok_q[b][i] && od_q[b][8*i +: 8] !== frame_bytes[b*S + i]) begin
                        n_fail++;
                        $display("FAIL split%0d_data: beat %0d lane %0d = %h, required %h",
                                 t, b, i, od_q[b][8*i +: 8], frame_bytes[b*S + i]);
                        break;
                    end
                end
            end
            if (nbeats[t] == 2) begin
                n_checks++;
                if (ok_q[0] !== 8'hFF || ol_q[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL split%0d_first: keep=%h last=%b, required ff 0", t, ok_q[0], ol_q[0]);
                end
            end
        end
    endtask

    task automatic test_runt();
        clear_q();
        runt_cycles = 0;
        make_frame(0, 9, 1'b0);
        send_frame();
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (od_q.size() != 0 || runt_cycles != 1) begin
            n_fail++;
            $display("FAIL runt: beats=%0d runt_cycles=%0d, required 0 and 1", od_q.size(), runt_cycles);
        end
        clear_q();
        make_frame(16, 11, 1'b0);
        send_frame();
        wait_beats(2, "after_runt");
        n_checks++;
        if (ok_q[1] !== 8'hFF || ol_q[1] !== 1'b1 || of_q[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL after_runt: keep=%h last=%b ok=%b, required ff 1 1", ok_q[1], ol_q[1], of_q[1]);
        end
    endtask

    logic [7:0] bp_bytes [0:49][0:63];
    int         bp_plen [0:49];
    bit         bp_bad [0:49];

    task automatic test_back_to_back();
        int total, qi, got;
        bit bytes_ok, last_seen, okv;
        clear_q();
        stall_changes = 0;
        total = 0;
        rand_ready = 1;
        for (int f = 0; f < 50; f++) begin
            bp_plen[f] = $urandom_range(1, 40);
            bp_bad[f]  = ($urandom_range(0, 4) == 0);
            make_frame(bp_plen[f], f + 100, bp_bad[f]);
            for (int i = 0; i < 64; i++) bp_bytes[f][i] = frame_bytes[i];
            total += (bp_plen[f] + S - 1) / S;
            send_frame();
        end
        wait_beats(total, "backpressure");
        rand_ready = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        qi = 0;
        for (int f = 0; f < 50; f++) begin
            got = 0; bytes_ok = 1; last_seen = 0; okv = 0;
            while (!last_seen && qi < od_q.size()) begin
                for (int i = 0; i < S; i++) begin
                    if (ok_q[qi][i]) begin
                        if (got >= bp_plen[f] || od_q[qi][8*i +: 8] !== bp_bytes[f][got]) bytes_ok = 0;
                        got++;
                    end
                end
                if (ol_q[qi]) begin
                    last_seen = 1;
                    okv = of_q[qi];
                end else if (ok_q[qi] !== 8'hFF) begin
                    bytes_ok = 0;
                end
                qi++;
            end
            n_checks++;
            if (!bytes_ok || !last_seen || got != bp_plen[f] || okv !== !bp_bad[f]) begin
                n_fail++;
                $display("FAIL bp_frame%0d: bytes %0d match=%b last=%b ok=%b, required %0d 1 1 %b",
                         f, got, bytes_ok, last_seen, okv, bp_plen[f], !bp_bad[f]);
            end
        end
        n_checks++;
        if (qi != od_q.size() || stall_changes != 0) begin
            n_fail++;
            $display("FAIL bp_stability: beats used %0d of %0d, stall changes %0d, required equal and 0",
                     qi, od_q.size(), stall_changes);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        out_ready = 1'b0;
        make_frame(20, 42, 1'b0);
        drive_beat(64'h0807060504030201, 8'hFF, 1'b0);
        in_data = 64'h100F0E0D0C0B0A09; in_keep = 8'hFF; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_valid: out_valid=%b, required 1", out_valid);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out_valid=%b, required 0", out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        clear_q();
        make_frame(12, 5, 1'b0);
        send_frame();
        wait_beats(2, "post_reset");
        n_checks++;
        if (ok_q[1] !== 8'h0F || ol_q[1] !== 1'b1 || of_q[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: keep=%h last=%b ok=%b, required 0f 1 1", ok_q[1], ol_q[1], of_q[1]);
        end
`ifdef CRC_FCS_CHECKER_STATS_EN
        n_checks++;
        if (stat_good !== 32'd1 || stat_bad !== 32'd0) begin
            n_fail++;
            $display("FAIL stats: good=%0d bad=%0d, required 1 0", stat_good, stat_bad);
        end
`endif
    endtask

    initial begin
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
        test_reset();
        test_good_frame(8'h26, 1'b1, "good");
        test_good_frame(8'h27, 1'b0, "bad");
        test_fcs_split();
        test_runt();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
